// File: rtl/lsq_mem_issuer_pkg.sv
// Shared types and constants for the load/store queue and its memory-request FSM.
package lsq_mem_issuer_pkg;

  localparam int LSQ_MEM_WORDS = 1024;
  localparam int LSQ_ROBEN_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BCAST = 2'd2
  } lsq_state_e;

  typedef struct packed {
    logic                   is_store;
    logic [LSQ_ROBEN_W-1:0] roben;
    logic [31:0]            addr;
    logic [31:0]            data;
    logic                   committed;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_fifo.sv
// Circular buffer of memory ops in program order, with head-commit marking and selective flush.
module lsq_fifo
  import lsq_mem_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  lsq_entry_t             push_entry_i,
  input  logic                   pop_i,
  input  logic                   commit_i,
  input  logic [LSQ_ROBEN_W-1:0] commit_tag_i,
  input  logic                   flush_i,
  output lsq_entry_t             head_o,
  output logic                   head_valid_o,
  output logic                   full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, head_commit, head_keep;

  always_comb begin
    head_o       = mem_q[head_q];
    head_valid_o = (count_q != '0);
    full_o       = (count_q == CNT_W'(DEPTH));
    do_pop       = pop_i && head_valid_o;
    // A pop in the same cycle frees a slot, so a push is accepted even when full.
    do_push      = push_i && !flush_i && (!full_o || do_pop);
    head_commit  = commit_i && head_valid_o && head_o.is_store && (head_o.roben == commit_tag_i);
    head_keep    = head_valid_o && !do_pop && head_o.is_store && (head_o.committed || head_commit);
    head_d       = head_q + PTR_W'(do_pop);
    tail_d       = tail_q;
    count_d      = count_q;
    if (flush_i) begin
      // Only the head can ever be committed, so at most one entry survives a flush.
      tail_d  = head_keep ? head_d + PTR_W'(1) : head_d;
      count_d = head_keep ? CNT_W'(1) : '0;
    end else begin
      tail_d  = tail_q + PTR_W'(do_push);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is only observed through count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (head_commit) mem_q[head_q].committed <= 1'b1;
    if (do_push) begin
      mem_q[tail_q]           <= push_entry_i;
      mem_q[tail_q].committed <= 1'b0;
    end
  end

endmodule

// File: rtl/lsq_mem_issuer.sv
// In-order LSQ front end: issues one memory request at a time and broadcasts load results on the CDB.
module lsq_mem_issuer
  import lsq_mem_issuer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = LSQ_MEM_WORDS,
  parameter int ROBEN_W   = LSQ_ROBEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LSQ_alloc_valid,
  input  logic               LSQ_alloc_is_store,
  input  logic [ROBEN_W-1:0] LSQ_alloc_ROBEN,
  input  logic [31:0]        LSQ_alloc_address,
  input  logic [31:0]        LSQ_alloc_data,
  output logic               LSQ_full,
  input  logic               ROB_commit_store,
  input  logic [ROBEN_W-1:0] ROB_commit_ROBEN,
  input  logic               ROB_flush,
  output logic [ROBEN_W-1:0] ROBEN,
  output logic               Read_en,
  output logic               Write_en,
  output logic [31:0]        address,
  output logic [31:0]        data,
  input  logic [31:0]        MEMU_Result,
  input  logic [ROBEN_W-1:0] MEMU_ROBEN,
  output logic               CDB_valid,
  output logic [ROBEN_W-1:0] CDB_ROBEN,
  output logic [31:0]        CDB_value,
  output logic               CDB_exception,
  input  logic               CDB_grant,
  output logic               store_fault,
  output logic [1:0]         dbg_state
);

  lsq_state_e         state_q, state_d;
  lsq_entry_t         alloc_entry, head;
  logic               head_valid, pop, head_in_range;
  logic               read_en_q, read_en_d, write_en_q, write_en_d, req_load_q, req_load_d;
  logic [ROBEN_W-1:0] roben_q, roben_d, cdb_roben_q, cdb_roben_d;
  logic [31:0]        addr_q, addr_d, data_q, data_d, cdb_value_q, cdb_value_d;
  logic               cdb_valid_q, cdb_valid_d, cdb_exc_q, cdb_exc_d;
  logic               store_fault_q, store_fault_d;

  assign alloc_entry = '{is_store:  LSQ_alloc_is_store,
                         roben:     LSQ_ROBEN_W'(LSQ_alloc_ROBEN),
                         addr:      LSQ_alloc_address,
                         data:      LSQ_alloc_data,
                         committed: 1'b0};

  lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (LSQ_alloc_valid),
    .push_entry_i (alloc_entry),
    .pop_i        (pop),
    .commit_i     (ROB_commit_store),
    .commit_tag_i (LSQ_ROBEN_W'(ROB_commit_ROBEN)),
    .flush_i      (ROB_flush),
    .head_o       (head),
    .head_valid_o (head_valid),
    .full_o       (LSQ_full)
  );

  assign head_in_range = (head.addr < 32'(MEM_WORDS));

  // CDB handshake: CDB_valid rises with the result; tag/value/exception stay stable
  // until the first posedge sampling CDB_grant=1, which retires the broadcast.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    read_en_d     = 1'b0;
    write_en_d    = 1'b0;
    req_load_d    = req_load_q;
    roben_d       = roben_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cdb_valid_d   = cdb_valid_q;
    cdb_roben_d   = cdb_roben_q;
    cdb_value_d   = cdb_value_q;
    cdb_exc_d     = cdb_exc_q;
    store_fault_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (head_valid && !head.is_store && !ROB_flush) begin
          pop = 1'b1;
          if (head_in_range) begin
            read_en_d  = 1'b1;
            req_load_d = 1'b1;
            roben_d    = ROBEN_W'(head.roben);
            addr_d     = head.addr;
            state_d    = S_REQ;
          end else begin
            cdb_valid_d = 1'b1;
            cdb_roben_d = ROBEN_W'(head.roben);
            cdb_value_d = '0;
            cdb_exc_d   = 1'b1;
            state_d     = S_BCAST;
          end
        end else if (head_valid && head.is_store && head.committed) begin
          pop = 1'b1;
          if (head_in_range) begin
            write_en_d = 1'b1;
            req_load_d = 1'b0;
            roben_d    = ROBEN_W'(head.roben);
            addr_d     = head.addr;
            data_d     = head.data;
            state_d    = S_REQ;
          end else begin
            store_fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_d = S_IDLE;
        // A flushed load still finishes its memory cycle but never reaches the CDB.
        if (req_load_q && !ROB_flush) begin
          cdb_valid_d = 1'b1;
          cdb_roben_d = MEMU_ROBEN;
          cdb_value_d = MEMU_Result;
          cdb_exc_d   = 1'b0;
          state_d     = S_BCAST;
        end
      end
      S_BCAST: begin
        if (CDB_grant || ROB_flush) begin
          cdb_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      read_en_q     <= 1'b0;
      write_en_q    <= 1'b0;
      req_load_q    <= 1'b0;
      roben_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_roben_q   <= '0;
      cdb_value_q   <= '0;
      cdb_exc_q     <= 1'b0;
      store_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_en_q     <= read_en_d;
      write_en_q    <= write_en_d;
      req_load_q    <= req_load_d;
      roben_q       <= roben_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_roben_q   <= cdb_roben_d;
      cdb_value_q   <= cdb_value_d;
      cdb_exc_q     <= cdb_exc_d;
      store_fault_q <= store_fault_d;
    end
  end

  // The memory unit must echo the tag of the load it was handed.
  mem_tag_echo: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_REQ && read_en_q) |-> (MEMU_ROBEN == roben_q));

  assign ROBEN         = roben_q;
  assign Read_en       = read_en_q;
  assign Write_en      = write_en_q;
  assign address       = addr_q;
  assign data          = data_q;
  assign CDB_valid     = cdb_valid_q;
  assign CDB_ROBEN     = cdb_roben_q;
  assign CDB_value     = cdb_value_q;
  assign CDB_exception = cdb_exc_q;
  assign store_fault   = store_fault_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsq_mem_issuer.sv
// Directed bench for lsq_mem_issuer with a negedge-sampling data memory model.
module tb_lsq_mem_issuer;

  logic        clk, rst;
  logic        LSQ_alloc_valid, LSQ_alloc_is_store;
  logic [4:0]  LSQ_alloc_ROBEN;
  logic [31:0] LSQ_alloc_address, LSQ_alloc_data;
  logic        LSQ_full;
  logic        ROB_commit_store, ROB_flush;
  logic [4:0]  ROB_commit_ROBEN;
  logic [4:0]  ROBEN;
  logic        Read_en, Write_en;
  logic [31:0] address, data;
  logic [31:0] MEMU_Result;
  logic [4:0]  MEMU_ROBEN;
  logic        CDB_valid, CDB_exception, CDB_grant, store_fault;
  logic [4:0]  CDB_ROBEN;
  logic [31:0] CDB_value;
  logic [1:0]  dbg_state;

  logic [113:0] outs;
  logic [31:0]  mem [1024];
  logic [36:0]  exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  lsq_mem_issuer #(.DEPTH(4), .MEM_WORDS(1024), .ROBEN_W(5)) dut (
    .clk(clk), .rst(rst),
    .LSQ_alloc_valid(LSQ_alloc_valid), .LSQ_alloc_is_store(LSQ_alloc_is_store),
    .LSQ_alloc_ROBEN(LSQ_alloc_ROBEN), .LSQ_alloc_address(LSQ_alloc_address),
    .LSQ_alloc_data(LSQ_alloc_data), .LSQ_full(LSQ_full),
    .ROB_commit_store(ROB_commit_store), .ROB_commit_ROBEN(ROB_commit_ROBEN),
    .ROB_flush(ROB_flush), .ROBEN(ROBEN), .Read_en(Read_en), .Write_en(Write_en),
    .address(address), .data(data), .MEMU_Result(MEMU_Result), .MEMU_ROBEN(MEMU_ROBEN),
    .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_value(CDB_value),
    .CDB_exception(CDB_exception), .CDB_grant(CDB_grant), .store_fault(store_fault),
    .dbg_state(dbg_state)
  );

  assign outs = {LSQ_full, Read_en, Write_en, ROBEN, address, data, CDB_valid, CDB_ROBEN,
                 CDB_value, CDB_exception, store_fault, dbg_state};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: acts at mid-cycle on the registered request.
  always @(negedge clk) begin
    if (Read_en) begin
      MEMU_Result <= mem[address[9:0]];
      MEMU_ROBEN  <= ROBEN;
    end
    if (Write_en) mem[address[9:0]] <= data;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic st, input logic [4:0] tag, input logic [31:0] a,
                          input logic [31:0] d);
    LSQ_alloc_valid    = 1'b1;
    LSQ_alloc_is_store = st;
    LSQ_alloc_ROBEN    = tag;
    LSQ_alloc_address  = a;
    LSQ_alloc_data     = d;
    tick();
    LSQ_alloc_valid    = 1'b0;
  endtask

  task automatic do_commit(input logic [4:0] tag);
    ROB_commit_store = 1'b1;
    ROB_commit_ROBEN = tag;
    tick();
    ROB_commit_store = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst = 1'b1;
    tick();
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
  endtask

  task automatic test_load_basic();
    CDB_grant = 1'b1;
    do_alloc(1'b0, 5'd3, 32'd10, 32'd0);
    n_checks++; if (Read_en !== 1'b0) begin n_fail++; $display("FAIL ld_rd_before_issue got=%b exp=0", Read_en); end
    tick();
    n_checks++; if ({Read_en, ROBEN, address} !== {1'b1, 5'd3, 32'd10}) begin n_fail++;
      $display("FAIL ld_issue got=%b/%0d/%0d exp=1/3/10", Read_en, ROBEN, address); end
    tick();
    n_checks++; if ({Read_en, CDB_valid, CDB_ROBEN, CDB_value, CDB_exception} !== {1'b0, 1'b1, 5'd3, 32'h55, 1'b0}) begin
      n_fail++; $display("FAIL ld_cdb got=%b/%b/%0d/%h/%b exp=0/1/3/55/0", Read_en, CDB_valid, CDB_ROBEN, CDB_value, CDB_exception); end
    tick();
    n_checks++; if ({CDB_valid, dbg_state} !== 3'b000) begin n_fail++;
      $display("FAIL ld_grant_release got=%b/%0d exp=0/0", CDB_valid, dbg_state); end
  endtask

  task automatic test_store_commit();
    CDB_grant = 1'b1;
    do_alloc(1'b1, 5'd4, 32'd20, 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (Write_en !== 1'b0) begin n_fail++; $display("FAIL st_no_write_precommit got=%b exp=0", Write_en); end
    end
    do_commit(5'd4);
    n_checks++; if (Write_en !== 1'b0) begin n_fail++; $display("FAIL st_commit_edge got=%b exp=0", Write_en); end
    tick();
    n_checks++; if ({Write_en, Read_en, address, data} !== {1'b1, 1'b0, 32'd20, 32'd7}) begin n_fail++;
      $display("FAIL st_issue got=%b/%b/%0d/%0d exp=1/0/20/7", Write_en, Read_en, address, data); end
    tick();
    n_checks++; if (Write_en !== 1'b0) begin n_fail++; $display("FAIL st_one_cycle got=%b exp=0", Write_en); end
    do_alloc(1'b0, 5'd5, 32'd20, 32'd0);
    tick();
    tick();
    n_checks++; if ({CDB_valid, CDB_ROBEN, CDB_value} !== {1'b1, 5'd5, 32'd7}) begin n_fail++;
      $display("FAIL st_readback got=%b/%0d/%0d exp=1/5/7", CDB_valid, CDB_ROBEN, CDB_value); end
    tick();
  endtask

  task automatic test_out_of_range();
    CDB_grant = 1'b1;
    do_alloc(1'b0, 5'd6, 32'd2000, 32'd0);
    tick();
    n_checks++; if ({Read_en, CDB_valid, CDB_ROBEN, CDB_value, CDB_exception} !== {1'b0, 1'b1, 5'd6, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL oor_load got=%b/%b/%0d/%h/%b exp=0/1/6/0/1", Read_en, CDB_valid, CDB_ROBEN, CDB_value, CDB_exception); end
    tick();
    n_checks++; if ({CDB_valid, Read_en} !== 2'b00) begin n_fail++; $display("FAIL oor_load_release got=%b%b exp=00", CDB_valid, Read_en); end
    do_alloc(1'b1, 5'd7, 32'd5000, 32'd9);
    do_commit(5'd7);
    tick();
    n_checks++; if ({store_fault, Write_en} !== 2'b10) begin n_fail++; $display("FAIL oor_store got=%b%b exp=10", store_fault, Write_en); end
    tick();
    n_checks++; if ({store_fault, Write_en, dbg_state} !== 4'b0000) begin n_fail++;
      $display("FAIL oor_store_pulse got=%b%b/%0d exp=00/0", store_fault, Write_en, dbg_state); end
  endtask

  task automatic test_full_wrap();
    logic [36:0] got, exp;
    CDB_grant = 1'b1;
    do_alloc(1'b1, 5'd8, 32'd40, 32'hA);
    do_alloc(1'b0, 5'd9, 32'd41, 32'd0);
    do_alloc(1'b0, 5'd10, 32'd42, 32'd0);
    do_alloc(1'b0, 5'd11, 32'd43, 32'd0);
    n_checks++; if (LSQ_full !== 1'b1) begin n_fail++; $display("FAIL full_set got=%b exp=1", LSQ_full); end
    do_alloc(1'b0, 5'd13, 32'd45, 32'd0);
    n_checks++; if (LSQ_full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop got=%b exp=1", LSQ_full); end
    do_commit(5'd8);
    n_checks++; if (Write_en !== 1'b0) begin n_fail++; $display("FAIL full_commit_edge got=%b exp=0", Write_en); end
    tick();
    n_checks++; if ({Write_en, address, data, LSQ_full} !== {1'b1, 32'd40, 32'hA, 1'b0}) begin n_fail++;
      $display("FAIL full_store_issue got=%b/%0d/%h/%b exp=1/40/a/0", Write_en, address, data, LSQ_full); end
    do_alloc(1'b0, 5'd12, 32'd44, 32'd0);
    exp_q.push_back({5'd9, 32'h1000 + 32'd41});
    exp_q.push_back({5'd10, 32'h1000 + 32'd42});
    exp_q.push_back({5'd11, 32'h1000 + 32'd43});
    exp_q.push_back({5'd12, 32'h1000 + 32'd44});
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      tick();
      if (CDB_valid) begin
        got = {CDB_ROBEN, CDB_value};
        exp = exp_q.pop_front();
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL full_drain got=%h exp=%h", got, exp); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout got=%0d left exp=0", exp_q.size()); end
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if ({CDB_valid, Read_en} !== 2'b00) begin n_fail++; $display("FAIL full_dropped_alloc got=%b%b exp=00", CDB_valid, Read_en); end
    end
    n_checks++; if (mem[40] !== 32'hA) begin n_fail++; $display("FAIL full_store_mem got=%h exp=a", mem[40]); end
  endtask

  task automatic test_grant_stall();
    CDB_grant = 1'b0;
    do_alloc(1'b0, 5'd14, 32'd50, 32'd0);
    do_alloc(1'b0, 5'd15, 32'd51, 32'd0);
    n_checks++; if ({Read_en, ROBEN} !== {1'b1, 5'd14}) begin n_fail++; $display("FAIL stall_issue got=%b/%0d exp=1/14", Read_en, ROBEN); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({CDB_valid, CDB_ROBEN, CDB_value, Read_en} !== {1'b1, 5'd14, 32'hBEEF, 1'b0}) begin n_fail++;
        $display("FAIL stall_hold cyc=%0d got=%b/%0d/%h/%b exp=1/14/beef/0", i, CDB_valid, CDB_ROBEN, CDB_value, Read_en); end
      if (i < 2) tick();
    end
    CDB_grant = 1'b1;
    tick();
    n_checks++; if ({CDB_valid, Read_en} !== 2'b00) begin n_fail++; $display("FAIL stall_release got=%b%b exp=00", CDB_valid, Read_en); end
    tick();
    n_checks++; if ({Read_en, ROBEN} !== {1'b1, 5'd15}) begin n_fail++; $display("FAIL stall_next_issue got=%b/%0d exp=1/15", Read_en, ROBEN); end
    tick();
    n_checks++; if ({CDB_valid, CDB_ROBEN, CDB_value} !== {1'b1, 5'd15, 32'h1000 + 32'd51}) begin n_fail++;
      $display("FAIL stall_next_cdb got=%b/%0d/%h", CDB_valid, CDB_ROBEN, CDB_value); end
    tick();
  endtask

  task automatic test_flush();
    CDB_grant = 1'b0;
    do_alloc(1'b0, 5'd17, 32'd61, 32'd0);
    do_alloc(1'b1, 5'd16, 32'd60, 32'h66);
    ROB_commit_store = 1'b1;
    ROB_commit_ROBEN = 5'd16;
    do_alloc(1'b0, 5'd18, 32'd62, 32'd0);
    ROB_commit_store = 1'b0;
    do_alloc(1'b0, 5'd19, 32'd63, 32'd0);
    n_checks++; if ({CDB_valid, CDB_ROBEN} !== {1'b1, 5'd17}) begin n_fail++; $display("FAIL flush_pre_bcast got=%b/%0d exp=1/17", CDB_valid, CDB_ROBEN); end
    ROB_flush = 1'b1;
    do_alloc(1'b0, 5'd20, 32'd64, 32'd0);
    ROB_flush = 1'b0;
    n_checks++; if ({CDB_valid, Write_en, Read_en} !== 3'b000) begin n_fail++;
      $display("FAIL flush_cancel got=%b%b%b exp=000", CDB_valid, Write_en, Read_en); end
    CDB_grant = 1'b1;
    tick();
    n_checks++; if ({Write_en, address, data} !== {1'b1, 32'd60, 32'h66}) begin n_fail++;
      $display("FAIL flush_store_survives got=%b/%0d/%h exp=1/60/66", Write_en, address, data); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++; if ({CDB_valid, Read_en, Write_en} !== 3'b000) begin n_fail++;
        $display("FAIL flush_no_loads cyc=%0d got=%b%b%b exp=000", c, CDB_valid, Read_en, Write_en); end
    end
    n_checks++; if (mem[60] !== 32'h66) begin n_fail++; $display("FAIL flush_store_mem got=%h exp=66", mem[60]); end
  endtask

  task automatic test_async_reset();
    CDB_grant = 1'b1;
    do_alloc(1'b0, 5'd21, 32'd70, 32'd0);
    tick();
    n_checks++; if (Read_en !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup got=%b exp=1", Read_en); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_req got=%h exp=0", outs); end
    #2 rst = 1'b1;
    tick();
    tick();
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL rst_after_release got=%h exp=0", outs); end
  endtask

  initial begin
    rst = 1'b0;
    LSQ_alloc_valid = 1'b0; LSQ_alloc_is_store = 1'b0; LSQ_alloc_ROBEN = '0;
    LSQ_alloc_address = '0; LSQ_alloc_data = '0;
    ROB_commit_store = 1'b0; ROB_commit_ROBEN = '0; ROB_flush = 1'b0; CDB_grant = 1'b0;
    MEMU_Result = '0; MEMU_ROBEN = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    mem[10] = 32'h55;
    mem[50] = 32'hBEEF;
    test_reset();
    test_load_basic();
    test_store_commit();
    test_out_of_range();
    test_full_wrap();
    test_grant_stall();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
